// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared types and default sizes for multi_channel_timer and timer_channel.
//   timer_state_e          : per-channel state (IDLE, RUN, DONE)
//   DEFAULT_WIDTH          : default counter / final-value width
//   DEFAULT_CHANNELS       : default number of channels
//   DEFAULT_PRESCALE_WIDTH : default width of the shared prescaler
// ---------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  localparam int DEFAULT_WIDTH          = 16;
  localparam int DEFAULT_CHANNELS       = 4;
  localparam int DEFAULT_PRESCALE_WIDTH = 8;

endpackage

// File: rtl/timer_channel.sv
// ---------------------------------------------------------------------------
// timer_channel
// One up-counting timer channel: FSM plus WIDTH-bit counter.
// Ports:
//   clock, reset  : single clock, synchronous active-high reset
//   tick          : count enable from the shared prescaler
//   active        : channel enable; low forces IDLE
//   periodic      : 1 = auto-reload on expiry, 0 = one-shot (latch done)
//   clear         : synchronous restart of the count
//   final_value   : terminal count
//   done          : one-shot expiry level (registered)
//   pulse         : one-cycle pulse on every expiry (registered)
// ---------------------------------------------------------------------------
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             active,
  input  logic             periodic,
  input  logic             clear,
  input  logic [WIDTH-1:0] final_value,
  output logic             done,
  output logic             pulse
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  timer_state_e     state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic             done_next, pulse_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      done  <= done_next;
      pulse <= pulse_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    done_next  = done;
    pulse_next = 1'b0;
    if (!active) begin
      state_next = IDLE;
      count_next = '0;
      done_next  = 1'b0;
    end else if (clear) begin
      // Clear wins over an expiry on the same edge, so no pulse here.
      state_next = RUN;
      count_next = '0;
      done_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_next = RUN;
          count_next = '0;
          done_next  = 1'b0;
        end
        RUN: begin
          if (tick) begin
            // >= rather than == so lowering final_value mid-run cannot wrap.
            if (count >= final_value) begin
              count_next = '0;
              pulse_next = 1'b1;
              if (!periodic) begin
                state_next = DONE;
                done_next  = 1'b1;
              end
            end else begin
              count_next = count + CNT_ONE;
            end
          end
        end
        DONE: begin
          count_next = '0;
          done_next  = 1'b1;
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
          done_next  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_channel_timer.sv
// ---------------------------------------------------------------------------
// multi_channel_timer
// N-channel up-counting timer with a shared prescaler.
// Build option: define TIMER_PRESCALER_EN to include the prescaler; when it is
// undefined, tick is tied high and prescale_value is ignored.
// Ports:
//   clock, reset       : single clock, synchronous active-high reset
//   prescale_value     : tick period minus one (0 = tick every cycle)
//   timer_active       : per-channel enable
//   timer_periodic     : per-channel mode, 1 = periodic, 0 = one-shot
//   timer_clear        : per-channel synchronous restart
//   timer_final_value  : channel i final value in [i*WIDTH +: WIDTH]
//   timer_done         : per-channel one-shot expiry level
//   timer_pulse        : per-channel one-cycle expiry pulse
// ---------------------------------------------------------------------------
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int CHANNELS       = DEFAULT_CHANNELS,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [PRESCALE_WIDTH-1:0] prescale_value,
  input  logic [CHANNELS-1:0]       timer_active,
  input  logic [CHANNELS-1:0]       timer_periodic,
  input  logic [CHANNELS-1:0]       timer_clear,
  input  logic [CHANNELS*WIDTH-1:0] timer_final_value,
  output logic [CHANNELS-1:0]       timer_done,
  output logic [CHANNELS-1:0]       timer_pulse
);

  logic tick;

`ifdef TIMER_PRESCALER_EN
  localparam logic [PRESCALE_WIDTH-1:0] PCNT_ONE = PRESCALE_WIDTH'(1);

  // Free-running and shared: a channel's first tick phase is arbitrary
  // within one prescale period.
  logic [PRESCALE_WIDTH-1:0] pcnt;

  assign tick = (pcnt >= prescale_value);

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_ONE;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale_value;
  assign tick            = 1'b1;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick),
      .active     (timer_active[i]),
      .periodic   (timer_periodic[i]),
      .clear      (timer_clear[i]),
      .final_value(timer_final_value[i*WIDTH +: WIDTH]),
      .done       (timer_done[i]),
      .pulse      (timer_pulse[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
module tb_multi_channel_timer;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int PW = 8;
`ifdef TIMER_PRESCALER_EN
  localparam bit PRESCALER_EN = 1'b1;
`else
  localparam bit PRESCALER_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [PW-1:0]   prescale_value;
  logic [CH-1:0]   timer_active;
  logic [CH-1:0]   timer_periodic;
  logic [CH-1:0]   timer_clear;
  logic [CH*W-1:0] timer_final_value;
  logic [CH-1:0]   timer_done;
  logic [CH-1:0]   timer_pulse;

  multi_channel_timer #(
    .WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .prescale_value   (prescale_value),
    .timer_active     (timer_active),
    .timer_periodic   (timer_periodic),
    .timer_clear      (timer_clear),
    .timer_final_value(timer_final_value),
    .timer_done       (timer_done),
    .timer_pulse      (timer_pulse)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [CH-1:0] active;
    logic [CH-1:0] exp_pulse;
    logic [CH-1:0] exp_done;
  } vec_t;

  vec_t tbl[20];

  // One rising edge, then sample at the following falling edge.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int k,
                         input logic [CH-1:0] ep, input logic [CH-1:0] ed);
    chk($sformatf("%s pulse k=%0d", name, k), timer_pulse, ep);
    chk($sformatf("%s done k=%0d", name, k), timer_done, ed);
  endtask

  task automatic set_final(input int ch, input logic [W-1:0] v);
    timer_final_value[ch*W +: W] = v;
  endtask

  task automatic do_reset(input string name);
    reset             = 1'b1;
    prescale_value    = '0;
    timer_active      = '0;
    timer_periodic    = '0;
    timer_clear       = '0;
    timer_final_value = '0;
    cyc();
    chk_out(name, 0, 4'b0000, 4'b0000);
    reset = 1'b0;
  endtask

  initial begin
    // ---------------- test 1: one-shot final 12 on ch0 (table) -----------
    for (int k = 0; k < 20; k++) begin
      tbl[k].active    = (k == 16) ? 4'b0000 : 4'b0001;
      tbl[k].exp_pulse = (k == 13) ? 4'b0001 : 4'b0000;
      tbl[k].exp_done  = (k >= 13 && k < 16) ? 4'b0001 : 4'b0000;
    end
    do_reset("reset1");
    set_final(0, 16'd12);
    for (int k = 0; k < 20; k++) begin
      timer_active = tbl[k].active;
      cyc();
      chk_out("oneshot12", k, tbl[k].exp_pulse, tbl[k].exp_done);
    end

    // ---------------- test 2: ch1 periodic final 3, ch3 periodic final 0 --
    do_reset("reset2");
    set_final(1, 16'd3);
    set_final(3, 16'd0);
    timer_periodic = 4'b1010;
    timer_active   = 4'b1010;
    begin
      int npulse = 0;
      for (int k = 0; k <= 20; k++) begin
        logic [CH-1:0] ep;
        cyc();
        ep = '0;
        if (k > 0 && (k % 4) == 0) ep[1] = 1'b1;
        if (k >= 1) ep[3] = 1'b1;
        if (timer_pulse[1]) npulse++;
        chk_out("periodic", k, ep, 4'b0000);
      end
      n_checks++;
      if (npulse != 5) begin
        n_fail++;
        $display("FAIL periodic pulse count: got %0d required 5", npulse);
      end
    end

    // ---------------- test 3: prescale 2, ch2 periodic final 1 -----------
    do_reset("reset3");
    prescale_value = 8'd2;
    set_final(2, 16'd1);
    timer_periodic = 4'b0100;
    timer_active   = 4'b0100;
    begin
      int  p     = PRESCALER_EN ? 6 : 2;
      bit  found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        cyc();
        if (timer_pulse[2]) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
        n_fail++;
        $display("FAIL prescale first pulse: got none in 20 cycles required one");
      end else begin
        for (int j = 1; j <= 3 * p; j++) begin
          cyc();
          chk_out("prescale", j, ((j % p) == 0) ? 4'b0100 : 4'b0000, 4'b0000);
        end
      end
    end

    // ---------------- test 4: clear on expiry edge, final 5 --------------
    do_reset("reset4");
    set_final(0, 16'd5);
    timer_active = 4'b0001;
    for (int k = 0; k <= 13; k++) begin
      timer_clear = (k == 6) ? 4'b0001 : 4'b0000;
      cyc();
      chk_out("clear", k, (k == 12) ? 4'b0001 : 4'b0000,
              (k >= 12) ? 4'b0001 : 4'b0000);
    end
    timer_clear = '0;

    // ---------------- test 5: lower final 20 -> 4 at count 10 -----------
    do_reset("reset5");
    set_final(0, 16'd20);
    timer_periodic = 4'b0001;
    timer_active   = 4'b0001;
    for (int k = 0; k <= 17; k++) begin
      set_final(0, (k >= 11) ? 16'd4 : 16'd20);
      cyc();
      chk_out("lower", k, (k == 11 || k == 16) ? 4'b0001 : 4'b0000, 4'b0000);
    end

    // ---------------- test 6: reset mid-count at 7 of 12 ----------------
    do_reset("reset6");
    set_final(0, 16'd12);
    timer_active = 4'b0001;
    for (int k = 0; k <= 23; k++) begin
      reset = (k == 8);
      cyc();
      chk_out("midreset", k, (k == 22) ? 4'b0001 : 4'b0000,
              (k >= 22) ? 4'b0001 : 4'b0000);
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
